// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and sizing helpers for the multiply/divide unit
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  localparam int MDU_WIDTH = 32;

  function automatic int mdu_cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one combinational iteration: shift-add multiply or restoring divide
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, operand};
    acc_next = acc;
    if (is_div) begin
      // remainder < divisor keeps a non-negative difference below 2^WIDTH, so diff[WIDTH] is the borrow
      if (diff[WIDTH])
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      if (acc[0])
        acc_next = {sum, acc[WIDTH-1:1]};
      else
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = mdu_cnt_width(WIDTH);

  mdu_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mag_b_q;
  logic [WIDTH-1:0]   raw_a_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               div_zero_q;

  logic               sgn_op;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    sgn_op   = (op == MDU_MULT) || (op == MDU_DIV);
    mag_a_in = (sgn_op && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    mag_b_in = (sgn_op && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    prod_fix = neg_res_q ? -acc : acc;
    quo_fix  = neg_res_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .acc      (acc),
    .operand  (mag_b_q),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      cnt        <= '0;
      acc        <= '0;
      mag_b_q    <= '0;
      raw_a_q    <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            acc        <= {{WIDTH{1'b0}}, mag_a_in};
            mag_b_q    <= mag_b_in;
            raw_a_q    <= operand_a;
            is_div_q   <= op[1];
            neg_res_q  <= sgn_op && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            neg_rem_q  <= (op == MDU_DIV) && operand_a[WIDTH-1];
            div_zero_q <= (operand_b == '0);
            cnt        <= CNT_W'(WIDTH - 1);
            state      <= CALC;
            busy       <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (cnt == '0) state <= FIX;
          else cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          if (!is_div_q) begin
            {hi, lo} <= prod_fix;
          end else if (div_zero_q) begin
            // divide by zero: fixed pattern, dividend passed through raw
            lo <= '1;
            hi <= raw_a_q;
          end else begin
            lo <= quo_fix;
            hi <= rem_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  // Called at a negedge; returns at the negedge of the done cycle (or after the cycle budget).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_cnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected %h", hi, 32'h0); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected %h", lo, 32'h0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu();
    int lat, bc;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL multu_latency: got %0d expected 34", lat); end
    n_checks++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
    @(negedge clk);
  endtask

  task automatic test_mult();
    int lat, bc;
    run_op(2'b00, 32'hFFFFFFFD, 32'h7, lat, bc);
    n_checks++; if (bc != 33) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected 33", bc); end
    n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo: got %h expected ffffffeb", lo); end
    @(negedge clk);
  endtask

  task automatic test_div();
    int lat, bc;
    run_op(2'b10, 32'hFFFFFFF9, 32'h2, lat, bc);
    n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
    @(negedge clk);
    run_op(2'b11, 32'h7, 32'h2, lat, bc);
    n_checks++; if (lo !== 32'h3) begin n_fail++; $display("FAIL divu_lo: got %h expected 00000003", lo); end
    n_checks++; if (hi !== 32'h1) begin n_fail++; $display("FAIL divu_hi: got %h expected 00000001", hi); end
    @(negedge clk);
  endtask

  task automatic test_div_edge();
    int lat, bc;
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    n_checks++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL div_min_lo: got %h expected 80000000", lo); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL div_min_hi: got %h expected 00000000", hi); end
    @(negedge clk);
    run_op(2'b11, 32'h5, 32'h0, lat, bc);
    n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu_zero_lo: got %h expected ffffffff", lo); end
    n_checks++; if (hi !== 32'h5) begin n_fail++; $display("FAIL divu_zero_hi: got %h expected 00000005", hi); end
    @(negedge clk);
  endtask

  task automatic test_ignore_and_abort();
    int n, seen;
    start = 1'b1; op = 2'b11; operand_a = 32'd100; operand_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 5) begin @(negedge clk); n++; end
    start = 1'b1; op = 2'b01; operand_a = 32'h1; operand_b = 32'h1;
    hi_we = 1'b1; wdata = 32'hAA;
    @(negedge clk); n++;
    start = 1'b0; hi_we = 1'b0;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_checks++; if (n != 34) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 34", n); end
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL ignore_lo: got %h expected 0000000e", lo); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL ignore_hi: got %h expected 00000002", hi); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_not_queued: got busy %b expected 0", busy); end

    start = 1'b1; op = 2'b01; operand_a = 32'd3; operand_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 10) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL abort_hi: got %h expected 00000000", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL abort_lo: got %h expected 00000000", lo); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done cycles expected 0", seen); end
  endtask

  task automatic test_mt_and_back_to_back();
    int lat, bc;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    n_checks++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL mthi: got %h expected 00001234", hi); end
    n_checks++; if (lo !== 32'h1234) begin n_fail++; $display("FAIL mtlo: got %h expected 00001234", lo); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mt_no_done: got %b expected 0", done); end
    @(negedge clk);
    run_op(2'b01, 32'd6, 32'd7, lat, bc);
    n_checks++; if (lo !== 32'd42) begin n_fail++; $display("FAIL b2b_first_lo: got %h expected 0000002a", lo); end
    run_op(2'b11, 32'd42, 32'd5, lat, bc);
    n_checks++; if (lat != 34) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
    n_checks++; if (lo !== 32'd8) begin n_fail++; $display("FAIL b2b_lo: got %h expected 00000008", lo); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL b2b_hi: got %h expected 00000002", hi); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_edge();
    test_ignore_and_abort();
    test_mt_and_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
